// File: rtl/psram_task_sched_if.sv
// ----------------------------------------------------------------------------
// psram_task_sched_if
//   Signal bundle between the DMA task scheduler, the PSRAM register file
//   (task list control, trigger routing, interrupt enable/clear) and the DMA
//   sequencing engine (run request / ack / done).
//
//   Handshake (run_req / run_ack): run_req is the "valid" side, run_ack the
//   "ready" side. A run transfers on the cycle where run_req and run_ack are
//   both high. While run_req is high, run_idx and run_desc_addr are stable
//   and run_req never drops before the transfer. run_done is a single-cycle
//   pulse from the engine marking the end of the transferred run.
//
//   Modports:
//     master : the scheduler (drives task_list, run_*, busy, irq*, sched_state)
//     slave  : register file + engine side (drives controls, triggers, ack/done)
//
//   sched_state is a debug view of the scheduler FSM state.
// ----------------------------------------------------------------------------
interface psram_task_sched_if #(
    parameter int NTASK = 8,
    parameter int NSRC  = 16,
    parameter int AW    = 17
);
    localparam int IW = $clog2(NTASK);

    // register-file side
    logic                 dma_en;
    logic                 task_load;
    logic                 task_add;
    logic                 task_remove;
    logic [NTASK-1:0]     task_val;
    logic [IW-1:0]        task_max;
    logic [4*NTASK-1:0]   task_trig;
    logic [AW-1:0]        task_table_addr;
    logic [NSRC-1:0]      trig_in;
    logic [NTASK-1:0]     task_list;
    logic [NTASK-1:0]     irq_en;
    logic [NTASK-1:0]     irq_clr;
    logic [NTASK-1:0]     irq_status;
    logic                 irq;

    // engine side
    logic                 run_req;
    logic [IW-1:0]        run_idx;
    logic [AW-1:0]        run_desc_addr;
    logic                 run_ack;
    logic                 run_done;
    logic                 busy;

    // debug
    logic [1:0]           sched_state;

    modport master (
        input  dma_en, task_load, task_add, task_remove, task_val, task_max,
               task_trig, task_table_addr, trig_in, irq_en, irq_clr,
               run_ack, run_done,
        output task_list, irq_status, irq, run_req, run_idx, run_desc_addr,
               busy, sched_state
    );

    modport slave (
        output dma_en, task_load, task_add, task_remove, task_val, task_max,
               task_trig, task_table_addr, trig_in, irq_en, irq_clr,
               run_ack, run_done,
        input  task_list, irq_status, irq, run_req, run_idx, run_desc_addr,
               busy, sched_state
    );
endinterface

// File: rtl/psram_task_sched.sv
// ----------------------------------------------------------------------------
// psram_task_sched
//   DMA task scheduler for the PSRAM controller. Holds the enabled-task list,
//   latches per-task triggers into a pending mask, picks the next eligible
//   task round-robin and issues one run request at a time to the DMA engine
//   together with the task's descriptor address. Completed runs set sticky
//   per-task status bits that feed a registered interrupt.
//
// Ports:
//   clk   : clock
//   rstn  : synchronous reset, active low
//   bus   : psram_task_sched_if.master (control, triggers, run handshake,
//           interrupt status, FSM debug state)
// ----------------------------------------------------------------------------
module psram_task_sched #(
    parameter int NTASK  = 8,
    parameter int NSRC   = 16,
    parameter int AW     = 17,
    parameter int DSHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    psram_task_sched_if.master     bus
);
    localparam int IW = $clog2(NTASK);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [NTASK-1:0]  task_list_q,  task_list_d;
    logic [NTASK-1:0]  pend_q,       pend_d;
    logic              run_req_q,    run_req_d;
    logic [IW-1:0]     run_idx_q,    run_idx_d;
    logic [AW-1:0]     run_addr_q,   run_addr_d;
    logic [IW-1:0]     last_idx_q,   last_idx_d;
    logic [NTASK-1:0]  irq_status_q, irq_status_d;
    logic              irq_q,        irq_d;

    logic [NTASK-1:0]  trig_hit;
    logic [NTASK-1:0]  eligible;
    logic [NTASK-1:0]  run_onehot;
    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand;
    logic              ack_fire;
    logic              done_fire;

    // Task list update: load, then add, then remove, so remove always wins.
    always_comb begin
        task_list_d = bus.task_load ? bus.task_val : task_list_q;
        if (bus.task_add) begin
            task_list_d = task_list_d | bus.task_val;
        end
        if (bus.task_remove) begin
            task_list_d = task_list_d & ~bus.task_val;
        end
    end

    // Per-task trigger routing and eligibility.
    always_comb begin
        trig_hit = '0;
        eligible = '0;
        for (int i = 0; i < NTASK; i++) begin
            trig_hit[i] = bus.trig_in[bus.task_trig[4*i +: 4]] & task_list_q[i];
            eligible[i] = pend_q[i] & task_list_q[i] & (IW'(i) <= bus.task_max);
        end
    end

    // Round-robin search starting just after the last granted index. The
    // k == NTASK step wraps back onto last_idx itself, so a lone eligible
    // task that was granted last time is still found.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NTASK; k++) begin
            cand = last_idx_q + IW'(k);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign run_onehot = NTASK'(1) << run_idx_q;
    assign ack_fire   = (state_q == ST_REQ)  && bus.run_ack;
    assign done_fire  = (state_q == ST_BUSY) && bus.run_done;

    // Scheduler FSM. Request outputs are only written on a grant, which keeps
    // them stable through REQ regardless of dma_en or list changes.
    always_comb begin
        state_d    = state_q;
        run_req_d  = run_req_q;
        run_idx_d  = run_idx_q;
        run_addr_d = run_addr_q;
        last_idx_d = last_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.dma_en && grant_found) begin
                    run_req_d  = 1'b1;
                    run_idx_d  = grant_idx;
                    // Address wraps within AW bits.
                    run_addr_d = bus.task_table_addr + (AW'(grant_idx) << DSHIFT);
                    last_idx_d = grant_idx;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.run_ack) begin
                    run_req_d = 1'b0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.run_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                run_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Pending: a new trigger beats the ack-clear of the same task, and a task
    // leaving the list drops its pending bit regardless.
    assign pend_d = ((pend_q & ~(ack_fire ? run_onehot : '0)) | trig_hit) & task_list_d;

    // Status clear beats a same-cycle completion.
    assign irq_status_d = (irq_status_q | (done_fire ? run_onehot : '0)) & ~bus.irq_clr;
    assign irq_d        = |(irq_status_q & bus.irq_en);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            task_list_q  <= '0;
            pend_q       <= '0;
            run_req_q    <= 1'b0;
            run_idx_q    <= '0;
            run_addr_q   <= '0;
            last_idx_q   <= IW'(NTASK - 1);
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            task_list_q  <= task_list_d;
            pend_q       <= pend_d;
            run_req_q    <= run_req_d;
            run_idx_q    <= run_idx_d;
            run_addr_q   <= run_addr_d;
            last_idx_q   <= last_idx_d;
            irq_status_q <= irq_status_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.task_list     = task_list_q;
    assign bus.run_req       = run_req_q;
    assign bus.run_idx       = run_idx_q;
    assign bus.run_desc_addr = run_addr_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.irq_status    = irq_status_q;
    assign bus.irq           = irq_q;
    assign bus.sched_state   = state_q;

endmodule

// File: tb/tb_psram_task_sched.sv
// ----------------------------------------------------------------------------
// tb_psram_task_sched
//   Directed scenarios followed by randomized traffic. A behavioural model
//   steps once per clock from the same inputs the DUT sees; every grant it
//   makes is pushed (cycle, index, address) into exp_q, and a monitor on the
//   falling edge pops and compares whenever run_req rises, while also
//   comparing the visible outputs against the model every cycle.
// ----------------------------------------------------------------------------
module tb_psram_task_sched;
    localparam int NTASK  = 8;
    localparam int NSRC   = 16;
    localparam int AW     = 17;
    localparam int DSHIFT = 4;
    localparam int EW     = 32 + 3 + AW;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    psram_task_sched_if #(.NTASK(NTASK), .NSRC(NSRC), .AW(AW)) bus();

    psram_task_sched #(.NTASK(NTASK), .NSRC(NSRC), .AW(AW), .DSHIFT(DSHIFT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  mon_en = 1'b0;
    bit  prev_req = 1'b0;

    bit  resp_en  = 1'b0;
    bit  man_ack  = 1'b0;
    bit  man_done = 1'b0;

    // reference model state
    bit             m_list[NTASK];
    bit             m_pend[NTASK];
    bit             m_stat[NTASK];
    bit             m_irq;
    bit             m_wait_ack;
    bit             m_running;
    int             m_cur;
    int             m_last;
    logic [AW-1:0]  m_addr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NTASK-1:0] pack_bits(input bit a[NTASK]);
        logic [NTASK-1:0] r;
        r = '0;
        for (int i = 0; i < NTASK; i++) r[i] = a[i];
        return r;
    endfunction

    // ---------------- reference model ----------------
    always @(posedge clk) begin : model
        bit nl[NTASK];
        int clr_idx;
        int done_idx;
        int g;
        int t;
        bit new_irq;
        bit hit;
        cyc++;
        if (!rstn) begin
            for (int i = 0; i < NTASK; i++) begin
                m_list[i] = 0; m_pend[i] = 0; m_stat[i] = 0;
            end
            m_irq = 0; m_wait_ack = 0; m_running = 0;
            m_cur = 0; m_last = NTASK - 1; m_addr = '0;
        end else begin
            for (int i = 0; i < NTASK; i++) begin
                nl[i] = bus.task_load ? bus.task_val[i] : m_list[i];
                if (bus.task_add && bus.task_val[i]) nl[i] = 1;
                if (bus.task_remove && bus.task_val[i]) nl[i] = 0;
            end
            new_irq = 0;
            for (int i = 0; i < NTASK; i++) if (m_stat[i] && bus.irq_en[i]) new_irq = 1;
            clr_idx = -1;
            done_idx = -1;
            if (m_wait_ack) begin
                if (bus.run_ack) begin
                    m_wait_ack = 0; m_running = 1; clr_idx = m_cur;
                end
            end else if (m_running) begin
                if (bus.run_done) begin
                    m_running = 0; done_idx = m_cur;
                end
            end else if (bus.dma_en) begin
                g = -1;
                for (int k = 1; k <= NTASK; k++) begin
                    t = (m_last + k) % NTASK;
                    if (g < 0 && m_pend[t] && m_list[t] && t <= int'(bus.task_max)) g = t;
                end
                if (g >= 0) begin
                    m_wait_ack = 1;
                    m_cur  = g;
                    m_last = g;
                    m_addr = AW'(int'(bus.task_table_addr) + g * (1 << DSHIFT));
                    exp_q.push_back({32'(cyc), 3'(g), m_addr});
                end
            end
            for (int i = 0; i < NTASK; i++) begin
                hit = bus.trig_in[bus.task_trig[4*i +: 4]] && m_list[i];
                if (i == clr_idx) m_pend[i] = 0;
                if (hit) m_pend[i] = 1;
                if (!nl[i]) m_pend[i] = 0;
                if (i == done_idx) m_stat[i] = 1;
                if (bus.irq_clr[i]) m_stat[i] = 0;
                m_list[i] = nl[i];
            end
            m_irq = new_irq;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (mon_en) begin
            chk("task_list",     64'(bus.task_list),     64'(pack_bits(m_list)));
            chk("irq_status",    64'(bus.irq_status),    64'(pack_bits(m_stat)));
            chk("irq",           64'(bus.irq),           64'(m_irq));
            chk("busy",          64'(bus.busy),          64'(m_wait_ack | m_running));
            chk("run_req",       64'(bus.run_req),       64'(m_wait_ack));
            chk("run_idx",       64'(bus.run_idx),       64'(m_cur));
            chk("run_desc_addr", 64'(bus.run_desc_addr), 64'(m_addr));
            if (bus.run_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL grant: unexpected request idx %0d addr %0h, none expected (cycle %0d)",
                             bus.run_idx, bus.run_desc_addr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", 64'({32'(cyc), bus.run_idx, bus.run_desc_addr}), 64'(e));
                end
            end
            prev_req = bus.run_req;
        end
    end

    // ---------------- engine responder ----------------
    initial begin
        bus.run_ack  = 1'b0;
        bus.run_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (resp_en) begin
                bus.run_ack  = bus.run_req ? ($urandom_range(0, 2) == 0)
                                           : ($urandom_range(0, 15) == 0);
                bus.run_done = (bus.busy && !bus.run_req) ? ($urandom_range(0, 3) == 0)
                                                          : ($urandom_range(0, 15) == 0);
            end else begin
                bus.run_ack  = man_ack;
                bus.run_done = man_done;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic list_op(input bit ld, input bit ad, input bit rm, input logic [7:0] val);
        bus.task_load = ld; bus.task_add = ad; bus.task_remove = rm; bus.task_val = val;
        tick();
        bus.task_load = 0; bus.task_add = 0; bus.task_remove = 0;
    endtask

    task automatic trig(input logic [NSRC-1:0] m);
        bus.trig_in = m;
        tick();
        bus.trig_in = '0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.run_req && n < 20) begin
            tick();
            n++;
        end
        chk("wait_run_req", 64'(bus.run_req), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.dma_en = 0; bus.task_load = 0; bus.task_add = 0; bus.task_remove = 0;
        bus.task_val = '0; bus.task_max = 3'd7; bus.task_trig = 32'h7654_3210;
        bus.task_table_addr = 17'h01000; bus.trig_in = '0;
        bus.irq_en = 8'hFF; bus.irq_clr = '0;
        rstn = 0;
        tick();
        mon_en = 1;
        idle(2);
        rstn = 1;
        resp_en = 1;

        // tasks 0 and 2: grants idx0 then idx2
        bus.dma_en = 1;
        list_op(1, 0, 0, 8'h05);
        trig(16'h0005);
        idle(30);

        // task_max limits grants to 0 and 1; 2 and 3 later when raised
        bus.task_max = 3'd1;
        list_op(1, 0, 0, 8'h0F);
        trig(16'h000F);
        idle(40);
        bus.task_max = 3'd7;
        idle(40);

        // round-robin between continuously re-pending tasks 1 and 3
        list_op(1, 0, 0, 8'h0A);
        for (int i = 0; i < 60; i++) trig(16'h000A);
        idle(30);

        // simultaneous load+add+remove, then remove during REQ
        list_op(1, 0, 0, 8'hF0);
        list_op(1, 1, 1, 8'h0F);
        idle(5);
        resp_en = 0; man_ack = 0; man_done = 0;
        list_op(1, 0, 0, 8'h01);
        trig(16'h0001);
        wait_req();
        list_op(0, 0, 1, 8'h01);
        idle(5);
        resp_en = 1;
        idle(20);

        // interrupt status/irq for task 5, clear, and done+clear together
        resp_en = 0;
        bus.irq_en = 8'h20;
        list_op(1, 0, 0, 8'h20);
        trig(16'h0020);
        wait_req();
        man_ack = 1; tick(); man_ack = 0;
        idle(2);
        man_done = 1; tick(); man_done = 0;
        idle(3);
        bus.irq_clr = 8'h20; tick(); bus.irq_clr = '0;
        idle(2);
        trig(16'h0020);
        wait_req();
        man_ack = 1; tick(); man_ack = 0;
        idle(2);
        man_done = 1; bus.irq_clr = 8'h20; tick(); man_done = 0; bus.irq_clr = '0;
        idle(3);

        // descriptor address wrap, then reset while BUSY
        bus.task_table_addr = 17'h1FFF0;
        list_op(1, 0, 0, 8'h04);
        trig(16'h0004);
        wait_req();
        man_ack = 1; tick(); man_ack = 0;
        idle(2);
        rstn = 0; idle(2); rstn = 1;
        idle(3);
        bus.irq_en = 8'hFF;
        resp_en = 1;

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            bus.task_load   = ($urandom_range(0, 29) == 0);
            bus.task_add    = ($urandom_range(0, 19) == 0);
            bus.task_remove = ($urandom_range(0, 29) == 0);
            bus.task_val    = 8'($urandom);
            bus.trig_in     = 16'($urandom & $urandom & $urandom);
            bus.irq_clr     = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 49) == 0) bus.task_max = 3'($urandom);
            if ($urandom_range(0, 29) == 0) bus.dma_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) bus.task_trig = $urandom;
            if ($urandom_range(0, 99) == 0) bus.irq_en = 8'($urandom);
            if ($urandom_range(0, 199) == 0) bus.task_table_addr = 17'($urandom);
            rstn = (c != 1200);
            tick();
        end
        bus.task_load = 0; bus.task_add = 0; bus.task_remove = 0;
        bus.trig_in = '0; bus.irq_clr = '0; bus.dma_en = 1; rstn = 1;
        idle(60);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
